// File: rtl/fc_seq_if.sv
// Handshake and memory-address bundle between fc_seq_ctrl and its datapath/memories.
// The master side is the controller; the slave side is the engine around it.
interface fc_seq_if #(
  parameter int XW = 1,
  parameter int AW = 1
);
  logic          input_valid;
  logic          input_ready;
  logic          output_valid;
  logic          output_ready;
  logic [XW-1:0] waddr_x;
  logic          wr_en_x;
  logic          bank_x;
  logic [XW-1:0] addr_x;
  logic [AW-1:0] addr_w;
  logic          clear_acc;
  logic          en_acc;

  modport master (
    input  input_valid, output_ready,
    output input_ready, output_valid, waddr_x, wr_en_x, bank_x,
           addr_x, addr_w, clear_acc, en_acc
  );

  modport slave (
    output input_valid, output_ready,
    input  input_ready, output_valid, waddr_x, wr_en_x, bank_x,
           addr_x, addr_w, clear_acc, en_acc
  );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Sequencer for one fully-connected layer (y = W*x): loads x, walks rows, strobes the accumulator.
// Optional macro FC_SEQ_DBUF_EN double-buffers x so the next vector loads during compute.
module fc_seq_ctrl #(
  parameter int M = 6,
  parameter int N = 6
) (
  input  logic     clk,
  input  logic     reset,
  fc_seq_if.master bus
);

  localparam int AW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam logic [XW-1:0] K_LAST   = XW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);

  typedef enum logic [1:0] {LOAD, ISSUE, FLUSH, OUT} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] wcnt;
  logic [XW-1:0] k;
  logic [RW-1:0] row;
  logic [AW-1:0] addr_w_q;
  logic          en_acc_q;
  logic          in_ready;
  logic          in_hs;
  logic          out_hs;
  logic          fill_last;
  logic          row_last;
  logic          swap_ok;

  assign in_hs     = bus.input_valid && in_ready;
  assign out_hs    = (state == OUT) && bus.output_ready;
  assign fill_last = in_hs && (wcnt == K_LAST);
  assign row_last  = (row == ROW_LAST);

`ifdef FC_SEQ_DBUF_EN
  logic bank;
  logic bank_full;

  assign in_ready = !bank_full;
  assign swap_ok  = bank_full || fill_last;
  assign bus.bank_x = bank;

  // A bank that completes in LOAD is swapped in at once; one that completes during
  // compute waits (blocking input) until the last row of the current vector is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank      <= 1'b0;
      bank_full <= 1'b0;
    end else if (state == LOAD && fill_last) begin
      bank <= ~bank;
    end else if (out_hs && row_last && swap_ok) begin
      bank      <= ~bank;
      bank_full <= 1'b0;
    end else if (fill_last) begin
      bank_full <= 1'b1;
    end
  end
`else
  assign in_ready   = (state == LOAD);
  assign swap_ok    = 1'b0;
  assign bus.bank_x = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:  if (fill_last) state_nxt = ISSUE;
      ISSUE: if (k == K_LAST) state_nxt = FLUSH;
      FLUSH: state_nxt = OUT;
      OUT: begin
        if (out_hs) begin
          if (!row_last)    state_nxt = ISSUE;
          else if (swap_ok) state_nxt = ISSUE;
          else              state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // addr_w tracks row*N + k by increment only; it holds on the last k of a row so it
  // never passes M*N-1, and steps to the next row start on the output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt     <= '0;
      k        <= '0;
      row      <= '0;
      addr_w_q <= '0;
      en_acc_q <= 1'b0;
    end else begin
      en_acc_q <= (state == ISSUE);
      if (in_hs) wcnt <= (wcnt == K_LAST) ? '0 : wcnt + 1'b1;
      case (state)
        LOAD: begin
          if (fill_last) begin
            k        <= '0;
            row      <= '0;
            addr_w_q <= '0;
          end
        end
        ISSUE: begin
          k <= (k == K_LAST) ? '0 : k + 1'b1;
          if (k != K_LAST) addr_w_q <= addr_w_q + 1'b1;
        end
        OUT: begin
          if (out_hs) begin
            k <= '0;
            if (!row_last) begin
              row      <= row + 1'b1;
              addr_w_q <= addr_w_q + 1'b1;
            end else begin
              row      <= '0;
              addr_w_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.input_ready  = in_ready;
  assign bus.output_valid = (state == OUT);
  assign bus.wr_en_x      = in_hs;
  assign bus.waddr_x      = wcnt;
  assign bus.addr_x       = k;
  assign bus.addr_w       = addr_w_q;
  assign bus.clear_acc    = (state == ISSUE) && (k == '0);
  assign bus.en_acc       = en_acc_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Self-checking bench for fc_seq_ctrl: a 6x6 instance and a 1x1 instance on a shared clock.
// Expected weight addresses are queued when a vector is loaded and popped per issue cycle.
module tb_fc_seq_ctrl;

  localparam int M = 6;
  localparam int N = 6;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   exp_addr_q[$];

  always #5 clk = ~clk;

  fc_seq_if #(.XW(3), .AW(6)) bus6 ();
  fc_seq_if #(.XW(1), .AW(1)) bus1 ();

  fc_seq_ctrl #(.M(6), .N(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6));
  fc_seq_ctrl #(.M(1), .N(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic test_reset();
    reset = 1'b1;
    bus6.input_valid = 1'b0; bus6.output_ready = 1'b0;
    bus1.input_valid = 1'b0; bus1.output_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (bus6.output_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_output_valid: got %b expected 0", bus6.output_valid); end
    tests_run++; if (bus6.clear_acc !== 1'b0 || bus6.en_acc !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_acc_strobes: got clear=%b en=%b expected 0/0", bus6.clear_acc, bus6.en_acc); end
    tests_run++; if (bus6.addr_w !== 6'd0 || bus6.addr_x !== 3'd0 || bus6.waddr_x !== 3'd0) begin tests_failed++; $display("[TB] FAIL rst_addr: got w=%0d x=%0d wx=%0d expected 0", bus6.addr_w, bus6.addr_x, bus6.waddr_x); end
    tests_run++; if (bus6.bank_x !== 1'b0 || bus6.wr_en_x !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_bank_wr: got bank=%b wr=%b expected 0/0", bus6.bank_x, bus6.wr_en_x); end
    reset = 1'b0;
    @(negedge clk);
    #1;
    tests_run++; if (bus6.input_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_input_ready: got %b expected 1", bus6.input_ready); end
  endtask

  // Streams one x vector back-to-back and queues the addr_w walk it should produce.
  task automatic load_vector6();
    for (int r = 0; r < M; r++)
      for (int kk = 0; kk < N; kk++)
        exp_addr_q.push_back(r * N + kk);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus6.input_valid = 1'b1;
      #1;
      tests_run++; if (bus6.wr_en_x !== 1'b1 || int'(bus6.waddr_x) !== i) begin tests_failed++; $display("[TB] FAIL load_write: got wr=%b waddr=%0d expected 1/%0d", bus6.wr_en_x, bus6.waddr_x, i); end
    end
  endtask

  task automatic run_vector6(input int stall_row, input int stall_len, input int abort_row);
    int exp_a;
    int en_cnt;
    int outs;
    outs = 0;
    bus6.output_ready = 1'b1;
    for (int r = 0; r < M; r++) begin
      en_cnt = 0;
      for (int kk = 0; kk < N; kk++) begin
        @(negedge clk);
        bus6.input_valid  = (kk % 2 == 1);
        bus6.output_ready = (r != stall_row);
        #1;
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : -1;
        tests_run++; if (int'(bus6.addr_w) !== exp_a || int'(bus6.addr_x) !== kk) begin tests_failed++; $display("[TB] FAIL issue_addr r%0d k%0d: got w=%0d x=%0d expected w=%0d x=%0d", r, kk, bus6.addr_w, bus6.addr_x, exp_a, kk); end
        tests_run++; if (bus6.clear_acc !== (kk == 0)) begin tests_failed++; $display("[TB] FAIL clear_acc r%0d k%0d: got %b expected %b", r, kk, bus6.clear_acc, kk == 0); end
        tests_run++; if (bus6.output_valid !== 1'b0 || bus6.input_ready !== 1'b0 || bus6.wr_en_x !== 1'b0) begin tests_failed++; $display("[TB] FAIL issue_ctrl r%0d k%0d: got ov=%b ir=%b wr=%b expected 0/0/0", r, kk, bus6.output_valid, bus6.input_ready, bus6.wr_en_x); end
        en_cnt += int'(bus6.en_acc);
        if (r == abort_row && kk == 2) begin
          bus6.input_valid = 1'b0;
          reset = 1'b1;
          #1;
          tests_run++; if (bus6.addr_w !== 6'd0 || bus6.addr_x !== 3'd0 || bus6.clear_acc !== 1'b0 || bus6.en_acc !== 1'b0 || bus6.output_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_reset: got w=%0d x=%0d clr=%b en=%b ov=%b expected all 0", bus6.addr_w, bus6.addr_x, bus6.clear_acc, bus6.en_acc, bus6.output_valid); end
          @(negedge clk);
          reset = 1'b0;
          exp_addr_q.delete();
          return;
        end
      end
      @(negedge clk);
      bus6.input_valid = 1'b0;
      #1;
      tests_run++; if (bus6.en_acc !== 1'b1 || bus6.clear_acc !== 1'b0 || bus6.output_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush r%0d: got en=%b clr=%b ov=%b expected 1/0/0", r, bus6.en_acc, bus6.clear_acc, bus6.output_valid); end
      en_cnt += int'(bus6.en_acc);
      tests_run++; if (en_cnt !== N) begin tests_failed++; $display("[TB] FAIL en_acc_count r%0d: got %0d expected %0d", r, en_cnt, N); end
      if (r == stall_row) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          #1;
          tests_run++; if (bus6.output_valid !== 1'b1 || int'(bus6.addr_w) !== r * N + N - 1) begin tests_failed++; $display("[TB] FAIL stall r%0d s%0d: got ov=%b w=%0d expected 1/%0d", r, s, bus6.output_valid, bus6.addr_w, r * N + N - 1); end
        end
      end
      @(negedge clk);
      bus6.output_ready = 1'b1;
      #1;
      tests_run++; if (bus6.output_valid !== 1'b1 || bus6.en_acc !== 1'b0) begin tests_failed++; $display("[TB] FAIL out r%0d: got ov=%b en=%b expected 1/0", r, bus6.output_valid, bus6.en_acc); end
      outs += int'(bus6.output_valid);
    end
    tests_run++; if (outs !== M) begin tests_failed++; $display("[TB] FAIL output_count: got %0d expected %0d", outs, M); end
    @(negedge clk);
    #1;
    tests_run++; if (bus6.input_ready !== 1'b1 || bus6.output_valid !== 1'b0 || bus6.waddr_x !== 3'd0 || bus6.en_acc !== 1'b0) begin tests_failed++; $display("[TB] FAIL back_to_load: got ir=%b ov=%b wx=%0d en=%b expected 1/0/0/0", bus6.input_ready, bus6.output_valid, bus6.waddr_x, bus6.en_acc); end
  endtask

  task automatic test_full_vector();
    load_vector6();
    run_vector6(-1, 0, -1);
  endtask

  task automatic test_backpressure();
    load_vector6();
    run_vector6(2, 5, -1);
  endtask

  task automatic test_reset_mid_row();
    load_vector6();
    run_vector6(-1, 0, 3);
    load_vector6();
    run_vector6(-1, 0, -1);
  endtask

  task automatic test_m1n1();
    @(negedge clk);
    bus1.output_ready = 1'b0;
    bus1.input_valid = 1'b1;
    #1;
    tests_run++; if (bus1.input_ready !== 1'b1 || bus1.wr_en_x !== 1'b1 || bus1.waddr_x !== 1'b0) begin tests_failed++; $display("[TB] FAIL m1_load: got ir=%b wr=%b wx=%0d expected 1/1/0", bus1.input_ready, bus1.wr_en_x, bus1.waddr_x); end
    @(negedge clk);
    bus1.input_valid = 1'b0;
    #1;
    tests_run++; if (bus1.clear_acc !== 1'b1 || bus1.addr_w !== 1'b0 || bus1.output_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL m1_issue: got clr=%b w=%0d ov=%b expected 1/0/0", bus1.clear_acc, bus1.addr_w, bus1.output_valid); end
    @(negedge clk);
    #1;
    tests_run++; if (bus1.en_acc !== 1'b1 || bus1.output_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL m1_flush: got en=%b ov=%b expected 1/0", bus1.en_acc, bus1.output_valid); end
    @(negedge clk);
    bus1.output_ready = 1'b1;
    #1;
    tests_run++; if (bus1.output_valid !== 1'b1 || bus1.addr_w !== 1'b0) begin tests_failed++; $display("[TB] FAIL m1_out: got ov=%b w=%0d expected 1/0", bus1.output_valid, bus1.addr_w); end
    @(negedge clk);
    bus1.output_ready = 1'b0;
    #1;
    tests_run++; if (bus1.input_ready !== 1'b1 || bus1.output_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL m1_reload: got ir=%b ov=%b expected 1/0", bus1.input_ready, bus1.output_valid); end
  endtask

  // Second vector streams into the idle bank during compute; the swap skips LOAD.
  task automatic test_dbuf();
    load_vector6();
    exp_addr_q.delete();
    bus6.output_ready = 1'b1;
    for (int c = 0; c < M * (N + 2) + 1; c++) begin
      @(negedge clk);
      bus6.input_valid = (c < N) || (c == 20);
      #1;
      if (c < N) begin
        tests_run++; if (bus6.wr_en_x !== 1'b1 || int'(bus6.waddr_x) !== c || bus6.bank_x !== 1'b1) begin tests_failed++; $display("[TB] FAIL dbuf_fill c%0d: got wr=%b wx=%0d bank=%b expected 1/%0d/1", c, bus6.wr_en_x, bus6.waddr_x, bus6.bank_x, c); end
      end else if (c == N || c == 20 || c == M * (N + 2) - 1) begin
        tests_run++; if (bus6.input_ready !== 1'b0 || bus6.wr_en_x !== 1'b0) begin tests_failed++; $display("[TB] FAIL dbuf_full c%0d: got ir=%b wr=%b expected 0/0", c, bus6.input_ready, bus6.wr_en_x); end
      end else if (c == M * (N + 2)) begin
        tests_run++; if (bus6.bank_x !== 1'b0 || bus6.clear_acc !== 1'b1 || bus6.addr_w !== 6'd0 || bus6.input_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL dbuf_swap: got bank=%b clr=%b w=%0d ir=%b expected 0/1/0/1", bus6.bank_x, bus6.clear_acc, bus6.addr_w, bus6.input_ready); end
      end
    end
    bus6.input_valid = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef FC_SEQ_DBUF_EN
    test_dbuf();
`else
    test_full_vector();
    test_backpressure();
    test_reset_mid_row();
    test_m1n1();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
